// File: rtl/hal_pkg.sv
// -----------------------------------------------------------------------------
// hal_pkg: shared types and constants for the HAL CPU front end.
//   PC_W, INSTR_W   : program counter and instruction widths
//   fetch_entry_t   : {pc, instr} pair carried from fetch to decode
//   opcode_e        : major opcode field instr[15:13] (used by decode)
// -----------------------------------------------------------------------------
package hal_pkg;

    localparam int unsigned PC_W    = 13;
    localparam int unsigned INSTR_W = 16;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // SUB occupies two encodings; the low opcode bit is free for decode to use.
    typedef enum logic [2:0] {
        OP_JMP     = 3'b000,
        OP_JREL    = 3'b001,
        OP_LDA     = 3'b010,
        OP_STO     = 3'b011,
        OP_SUB     = 3'b100,
        OP_SUB_ALT = 3'b101,
        OP_ADD     = 3'b110,
        OP_RSVD    = 3'b111
    } opcode_e;

    function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[INSTR_W-1 -: 3]);
    endfunction

    function automatic logic is_sub(input opcode_e op);
        return (op == OP_SUB) || (op == OP_SUB_ALT);
    endfunction

endpackage

// File: rtl/hal_fetch_if.sv
// -----------------------------------------------------------------------------
// hal_fetch_if: fetch -> decode valid/ready channel.
//   out_valid : head entry is valid           (fetch -> decode)
//   out_ready : decode accepts the head entry (decode -> fetch)
//   out_instr : head instruction              (fetch -> decode)
//   out_pc    : address of head instruction   (fetch -> decode)
// master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface hal_fetch_if;
    import hal_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/hal_fetch_queue.sv
// -----------------------------------------------------------------------------
// hal_fetch_queue: Q_DEPTH-entry circular FIFO of fetch_entry_t.
//   clk, reset : clock, synchronous active-high reset
//   push       : enqueue wdata (caller guarantees room, counting a same-cycle pop)
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : discard all entries; overrides push and pop
//   wdata      : entry to enqueue
//   count      : number of valid entries
//   head       : oldest entry (registered storage, meaningful when count != 0)
// -----------------------------------------------------------------------------
module hal_fetch_queue
    import hal_pkg::*;
#(
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   wdata,
    output logic [$clog2(Q_DEPTH+1)-1:0]   count,
    output fetch_entry_t                   head
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
    localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    fetch_entry_t     mem_q [Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives in count_q.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hal_fetch.sv
// -----------------------------------------------------------------------------
// hal_fetch: instruction fetch stage of the HAL CPU.
//   clk, reset     : clock, synchronous active-high reset (highest priority)
//   redirect_valid : execute requests a PC change; flushes the fetch queue
//   redirect_pc    : new absolute fetch address (taken modulo IMEM_DEPTH)
//   imem_we        : instruction memory write enable (program load)
//   imem_waddr     : instruction memory write address
//   imem_wdata     : instruction memory write data
//   out_if         : {pc, instr} valid/ready channel to decode (master side)
//   pc             : next address to be fetched
// Owns the fetch PC and the instruction memory; buffering is in hal_fetch_queue.
// -----------------------------------------------------------------------------
module hal_fetch
    import hal_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 8,
    parameter int unsigned Q_DEPTH    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INSTR_W-1:0]            imem_wdata,
    hal_fetch_if.master                   out_if,
    output logic [PC_W-1:0]               pc
);

    localparam int unsigned AW    = $clog2(IMEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

    logic [AW-1:0]      rd_addr;
    logic [AW-1:0]      rd_addr_inc;
    logic [INSTR_W-1:0] fetch_instr;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic               out_valid;
    logic               push;
    logic               pop;

    // Upper redirect bits are discarded by the modulo-IMEM_DEPTH mapping.
    logic unused_redirect_hi;
    assign unused_redirect_hi = ^(redirect_pc >> AW);

    // pc_q never leaves [0, IMEM_DEPTH), so its low bits are the memory index.
    assign rd_addr     = pc_q[AW-1:0];
    assign rd_addr_inc = rd_addr + AW'(1);
    assign fetch_instr = imem_q[rd_addr];

    // out_valid depends only on registered count, never on out_ready.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_if.out_ready;
    assign push      = !redirect_valid && ((count < CNT_W'(Q_DEPTH)) || pop);

    assign push_entry = '{pc: pc_q, instr: fetch_instr};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = PC_W'(redirect_pc[AW-1:0]);
        end else if (push) begin
            pc_d = PC_W'(rd_addr_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Read is combinational from the pre-edge contents, so a same-address
    // write during a fetch enqueues the old word.
    always_ff @(posedge clk) begin
        if (imem_we && !reset) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    hal_fetch_queue #(
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .count (count),
        .head  (head)
    );

    assign out_if.out_valid = out_valid;
    assign out_if.out_instr = head.instr;
    assign out_if.out_pc    = head.pc;
    assign pc               = pc_q;

endmodule

// File: tb/tb_hal_fetch.sv
// -----------------------------------------------------------------------------
// tb_hal_fetch: self-checking bench for hal_fetch. Directed scenarios followed
// by random traffic, all compared every cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_hal_fetch;
    import hal_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned QD    = 2;

    logic               clk;
    logic               reset;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_we;
    logic [2:0]         imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [PC_W-1:0]    pc;

    hal_fetch_if u_if ();

    hal_fetch #(
        .IMEM_DEPTH (DEPTH),
        .Q_DEPTH    (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .out_if         (u_if),
        .pc             (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;

    // Reference model: memory array, integer pc, queue of pending entries.
    logic [INSTR_W-1:0] m_mem [DEPTH];
    int                 m_pc;
    fetch_entry_t       m_q [$];

    logic [INSTR_W-1:0] prog [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic rv, input logic [PC_W-1:0] rpc,
                              input logic we, input logic [2:0] wa,
                              input logic [INSTR_W-1:0] wd, input logic rdy);
        logic               do_pop;
        logic               do_push;
        logic [INSTR_W-1:0] fetched;
        fetch_entry_t       e;
        if (r) begin
            m_q.delete();
            m_pc = 0;
        end else begin
            do_pop  = (m_q.size() != 0) && rdy;
            do_push = !rv && ((m_q.size() < QD) || do_pop);
            fetched = m_mem[m_pc % DEPTH];
            if (rv) begin
                m_q.delete();
                m_pc = int'(rpc) % DEPTH;
            end else begin
                if (do_pop) e = m_q.pop_front();
                if (do_push) begin
                    e.pc    = PC_W'(m_pc);
                    e.instr = fetched;
                    m_q.push_back(e);
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
            if (we) m_mem[wa] = wd;
        end
    endtask

    task automatic compare_model();
        check_eq("valid", 32'(u_if.out_valid), 32'(m_q.size() != 0));
        check_eq("pc", 32'(pc), 32'(m_pc));
        if (m_q.size() != 0) begin
            check_eq("out_pc", 32'(u_if.out_pc), 32'(m_q[0].pc));
            check_eq("out_instr", 32'(u_if.out_instr), 32'(m_q[0].instr));
        end
    endtask

    // Called just after a falling edge: drive, clock, update model, compare.
    task automatic step(input logic r, input logic rv, input logic [PC_W-1:0] rpc,
                        input logic we, input logic [2:0] wa,
                        input logic [INSTR_W-1:0] wd, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_we        = we;
        imem_waddr     = wa;
        imem_wdata     = wd;
        u_if.out_ready = rdy;
        @(posedge clk);
        model_edge(r, rv, rpc, we, wa, wd, rdy);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, 1'b0, 3'd0, '0, rdy);
    endtask

    task automatic redir(input logic [PC_W-1:0] target);
        step(1'b0, 1'b1, target, 1'b0, 3'd0, '0, 1'b1);
    endtask

    initial begin
        logic               r_r, r_rv, r_we, r_rdy;
        logic [PC_W-1:0]    r_rpc;
        logic [2:0]         r_wa;
        logic [INSTR_W-1:0] r_wd;

        n_vec = 0;
        n_err = 0;
        m_pc  = 0;
        prog  = '{16'h0000, 16'h2001, 16'h4002, 16'h6003,
                  16'ha004, 16'hc005, 16'h6206, 16'h8007};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; u_if.out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 3'd0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 3'd0, '0, 1'b0);
        check_eq("rst_valid", 32'(u_if.out_valid), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'd0);

        // Program load, holding the queue empty with redirects to 0
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0, 1'b1, 3'(i), prog[i], 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b0, 3'd0, '0, 1'b0);

        // Streaming with wrap 7 -> 0
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            check_eq("stream_pc", 32'(u_if.out_pc), 32'(i % DEPTH));
            check_eq("stream_instr", 32'(u_if.out_instr), 32'(prog[i % DEPTH]));
        end
        idle(1'b1);
        check_eq("bp_start_pc", 32'(u_if.out_pc), 32'd2);

        // Backpressure: head holds, pc stalls at 4
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check_eq("bp_instr", 32'(u_if.out_instr), 32'h4002);
            check_eq("bp_pc", 32'(pc), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check_eq("bp_release", 32'(u_if.out_pc), 32'(3 + i));
        end

        // Redirect flush, then 5,6,7,0
        redir(13'd5);
        check_eq("redir_bubble", 32'(u_if.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check_eq("redir_pc", 32'(u_if.out_pc), 32'((5 + i) % DEPTH));
            check_eq("redir_instr", 32'(u_if.out_instr), 32'(prog[(5 + i) % DEPTH]));
        end

        // Redirect target wraps modulo depth
        redir(13'h000B);
        check_eq("mask_pc", 32'(pc), 32'd3);
        idle(1'b1);
        check_eq("mask_out_pc", 32'(u_if.out_pc), 32'd3);
        check_eq("mask_instr", 32'(u_if.out_instr), 32'h6003);

        // Write to the address being fetched: old word enqueued
        step(1'b0, 1'b0, '0, 1'b1, 3'd4, 16'hBEEF, 1'b1);
        check_eq("rbw_old", 32'(u_if.out_instr), 32'ha004);
        redir(13'd4);
        idle(1'b1);
        check_eq("rbw_new", 32'(u_if.out_instr), 32'hBEEF);

        // Reset beats a same-cycle redirect and imem write
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 13'd6, 1'b1, 3'd0, 16'h1234, 1'b0);
        check_eq("mid_rst_pc", 32'(pc), 32'd0);
        check_eq("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
        idle(1'b1);
        check_eq("mid_rst_first", 32'(u_if.out_pc), 32'd0);
        check_eq("mid_rst_instr", 32'(u_if.out_instr), 32'h0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r_r   = ($urandom_range(63) == 0);
            r_rv  = ($urandom_range(7) == 0);
            r_rpc = PC_W'($urandom_range(8191));
            r_we  = ($urandom_range(5) == 0);
            r_wa  = 3'($urandom_range(7));
            r_wd  = INSTR_W'($urandom);
            r_rdy = ($urandom_range(9) < 7);
            step(r_r, r_rv, r_rpc, r_we, r_wa, r_wd, r_rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
